seviye_dugum_uretici: RTL and testbench
=======================================

SEVIYE_DUGUM_URETICI -- requirements
Module: seviye_dugum_uretici

Interface
REQ-001 SHALL have parameter DUGUM_W, default 4: node-index width; valid levels 0..DUGUM_W-1; legal range 2..8.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port baslat, input, 1: start request, sampled in IDLE only.
REQ-005 SHALL have port seviye, input, 3: requested tree level, captured with baslat.
REQ-006 SHALL have port dugum, output, DUGUM_W: current node index (0-indexed binary heap).
REQ-007 SHALL have port dugum_gecerli, output, 1: dugum is valid.
REQ-008 SHALL have port dugum_hazir, input, 1: consumer accepts dugum this cycle.
REQ-009 SHALL have port kalan, output, DUGUM_W: nodes still to transfer, including the current one.
REQ-010 SHALL have port mesgul, output, 1: high in EMIT.
REQ-011 SHALL have port bitti, output, 1: one-cycle pulse after the last transfer.
REQ-012 SHALL have port hata, output, 1: one-cycle pulse on an illegal level request.

Function
REQ-013 SHALL enumerate every node n whose level is L, where L = floor(log2(n+1)), i.e. n = 2^L-1 .. 2^(L+1)-2, giving 2^L nodes.
REQ-014 SHALL implement the FSM states IDLE, EMIT, DONE.
REQ-015 IDLE with baslat=1 and seviye<DUGUM_W SHALL capture seviye, load dugum with the first node and kalan=2^L, and enter EMIT on the next edge.
REQ-016 IDLE with baslat=1 and seviye>=DUGUM_W SHALL pulse hata for one cycle and stay in IDLE, leaving dugum and kalan unchanged.
REQ-017 In EMIT, dugum_gecerli SHALL be 1, and dugum/kalan SHALL stay stable while dugum_hazir=0.
REQ-018 A transfer SHALL occur on each edge with dugum_gecerli=1 and dugum_hazir=1; kalan then decrements by 1 and dugum steps to the next node.
REQ-019 A transfer with kalan=1 SHALL enter DONE with dugum_gecerli=0 on the next cycle.
REQ-020 DONE SHALL assert bitti for exactly one cycle and return to IDLE unconditionally.
REQ-021 baslat SHALL be ignored in EMIT and DONE, including a baslat coincident with the last transfer.
REQ-022 Latency SHALL be one cycle from baslat to the first dugum_gecerli; throughput SHALL be one node per cycle with dugum_hazir held high.
REQ-023 Level 0 SHALL yield exactly one node (0) and then DONE.
REQ-024 The index arithmetic SHALL never wrap: the maximum index is 2^DUGUM_W-2, and the all-ones index is never emitted.
REQ-025 dugum_gecerli, mesgul, bitti and hata SHALL be registered outputs.

Reset
REQ-026 rst=1 SHALL force IDLE with dugum=0, kalan=0, and dugum_gecerli, mesgul, bitti, hata all 0 on the next edge.
REQ-027 rst during EMIT or DONE SHALL abort the sequence without a bitti pulse; rst SHALL take priority over baslat and transfers.

Configuration
REQ-028 With macro SEVIYE_TERS_SIRA_EN defined, the block SHALL enumerate in descending order, from 2^(L+1)-2 down to 2^L-1.
REQ-029 Without SEVIYE_TERS_SIRA_EN, the block SHALL enumerate in ascending order; kalan, handshake and timing SHALL be identical in both builds.

Verification
REQ-030 DUGUM_W=4, baslat with seviye=2, dugum_hazir=1 -> dugum 3,4,5,6 on consecutive cycles with kalan 4,3,2,1; then bitti pulses once.
REQ-031 seviye=3 with dugum_hazir toggling 1,0,1,0 -> dugum 7..14 each transferred once, held stable during stalls, 8 transfers total.
REQ-032 seviye=0 -> a single transfer of dugum=0 with kalan=1, then bitti; seviye=4 -> a one-cycle hata pulse, mesgul stays 0.
REQ-033 seviye=3 with rst asserted after 3 transfers -> next cycle is IDLE with all outputs 0 and no bitti; a fresh baslat then restarts at 7.
REQ-034 SEVIYE_TERS_SIRA_EN build, seviye=2 -> dugum 6,5,4,3 with kalan 4,3,2,1.
REQ-035 baslat held high throughout seviye=1 -> only dugum 1,2 are emitted; a new sequence starts only after bitti and the return to IDLE.

Source files
------------

// File: rtl/seviye_dugum_uretici.sv
// seviye_dugum_uretici
// Walks every node of one level of a 0-indexed binary heap and hands the
// node indices out one at a time over a valid/ready handshake.
//
// Level L holds nodes 2^L-1 .. 2^(L+1)-2, which is 2^L nodes in total.
//
// Optional build macro:
//   SEVIYE_TERS_SIRA_EN : when defined, nodes come out in descending order.
//                         Without it they come out in ascending order.
//                         The handshake, the kalan count and the timing are
//                         the same in both builds.
//
// Parameter:
//   DUGUM_W       node-index width; valid levels are 0..DUGUM_W-1 (2..8)
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   baslat        start request, only looked at while idle
//   seviye        requested tree level, captured together with baslat
//   dugum         current node index
//   dugum_gecerli dugum is valid
//   dugum_hazir   consumer accepts dugum this cycle
//   kalan         nodes still to hand out, current one included
//   mesgul        high while nodes are being handed out
//   bitti         one-cycle pulse after the last transfer
//   hata          one-cycle pulse on a start request with an illegal level
module seviye_dugum_uretici #(
  parameter int DUGUM_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               baslat,
  input  logic [2:0]         seviye,
  output logic [DUGUM_W-1:0] dugum,
  output logic               dugum_gecerli,
  input  logic               dugum_hazir,
  output logic [DUGUM_W-1:0] kalan,
  output logic               mesgul,
  output logic               bitti,
  output logic               hata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } durum_t;

  localparam logic [DUGUM_W-1:0] BIR = {{(DUGUM_W-1){1'b0}}, 1'b1};

  durum_t             r_durum;
  logic [DUGUM_W-1:0] r_dugum;
  logic [DUGUM_W-1:0] r_kalan;
  logic               r_gecerli;
  logic               r_mesgul;
  logic               r_bitti;
  logic               r_hata;

  logic               w_yasal;
  logic [DUGUM_W-1:0] w_adet;
  logic [DUGUM_W-1:0] w_ilk;
  logic [DUGUM_W-1:0] w_sonraki;

  // A level is legal only if its last node still fits in DUGUM_W bits.
  // For every legal level 2^L fits in DUGUM_W bits, so the node count and
  // the first index can be formed at DUGUM_W width without any wrap.
  // The descending start is written as (2^L-1)*2 so the 2^(L+1) term is
  // never formed, keeping the top index at 2^DUGUM_W-2.
  always_comb begin
    w_yasal = (32'(seviye) < DUGUM_W);
    w_adet  = BIR << seviye;
`ifdef SEVIYE_TERS_SIRA_EN
    w_ilk     = (w_adet - BIR) << 1;
    w_sonraki = r_dugum - BIR;
`else
    w_ilk     = w_adet - BIR;
    w_sonraki = r_dugum + BIR;
`endif
  end

  // Single sequencer: loads the level in IDLE, steps one node per accepted
  // transfer in EMIT, spends exactly one cycle in DONE for the bitti pulse.
  // On the last transfer the index is held rather than stepped, so it can
  // never move outside the level (and never reach the all-ones value).
  // bitti and hata default to zero each cycle, which makes them pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_durum   <= IDLE;
      r_dugum   <= '0;
      r_kalan   <= '0;
      r_gecerli <= 1'b0;
      r_mesgul  <= 1'b0;
      r_bitti   <= 1'b0;
      r_hata    <= 1'b0;
    end else begin
      r_bitti <= 1'b0;
      r_hata  <= 1'b0;
      case (r_durum)
        IDLE: begin
          if (baslat) begin
            if (w_yasal) begin
              r_durum   <= EMIT;
              r_dugum   <= w_ilk;
              r_kalan   <= w_adet;
              r_gecerli <= 1'b1;
              r_mesgul  <= 1'b1;
            end else begin
              r_hata <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (dugum_hazir) begin
            r_kalan <= r_kalan - BIR;
            if (r_kalan == BIR) begin
              r_durum   <= DONE;
              r_gecerli <= 1'b0;
              r_mesgul  <= 1'b0;
              r_bitti   <= 1'b1;
            end else begin
              r_dugum <= w_sonraki;
            end
          end
        end
        DONE: begin
          r_durum <= IDLE;
        end
        default: begin
          r_durum <= IDLE;
        end
      endcase
    end
  end

  assign dugum         = r_dugum;
  assign kalan         = r_kalan;
  assign dugum_gecerli = r_gecerli;
  assign mesgul        = r_mesgul;
  assign bitti         = r_bitti;
  assign hata          = r_hata;

endmodule

// File: tb/tb_seviye_dugum_uretici.sv
// Directed testbench for seviye_dugum_uretici with DUGUM_W=4.
// Expected node order follows SEVIYE_TERS_SIRA_EN the same way the design
// does, so the bench works for either build.
module tb_seviye_dugum_uretici;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         baslat;
  logic [2:0]   seviye;
  logic [W-1:0] dugum;
  logic         dugum_gecerli;
  logic         dugum_hazir;
  logic [W-1:0] kalan;
  logic         mesgul;
  logic         bitti;
  logic         hata;

  int vectors;
  int miscompares;

  seviye_dugum_uretici #(.DUGUM_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .baslat        (baslat),
    .seviye        (seviye),
    .dugum         (dugum),
    .dugum_gecerli (dugum_gecerli),
    .dugum_hazir   (dugum_hazir),
    .kalan         (kalan),
    .mesgul        (mesgul),
    .bitti         (bitti),
    .hata          (hata)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // i-th node of level L in the order the selected build hands them out
  function automatic logic [W-1:0] beklenen(input int L, input int i);
`ifdef SEVIYE_TERS_SIRA_EN
    return W'((2 << L) - 2 - i);
`else
    return W'((1 << L) - 1 + i);
`endif
  endfunction

  // Advance past the next rising edge; outputs are sampled and inputs are
  // driven 1 ns after it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset must clear every output
  task automatic test_reset;
    rst = 1'b1;
    baslat = 1'b0;
    seviye = 3'd0;
    dugum_hazir = 1'b0;
    tick();
    tick();
    vectors++;
    if ({dugum_gecerli, mesgul, bitti, hata} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {dugum_gecerli, mesgul, bitti, hata});
    end
    vectors++;
    if (dugum !== 4'd0 || kalan !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got dugum=%0d kalan=%0d expected 0/0", dugum, kalan);
    end
    rst = 1'b0;
    tick();
  endtask

  // Level 2 streamed with dugum_hazir high
  task automatic test_level2;
    dugum_hazir = 1'b1;
    seviye = 3'd2;
    baslat = 1'b1;
    tick();
    baslat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dugum_gecerli !== 1'b1 || mesgul !== 1'b1 || dugum !== beklenen(2, i) || kalan !== W'(4 - i)) begin
        miscompares++;
        $display("[TB] FAIL level2_node%0d: got v=%b m=%b dugum=%0d kalan=%0d expected v=1 m=1 dugum=%0d kalan=%0d",
                 i, dugum_gecerli, mesgul, dugum, kalan, beklenen(2, i), 4 - i);
      end
      tick();
    end
    vectors++;
    if (bitti !== 1'b1 || dugum_gecerli !== 1'b0 || mesgul !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL level2_done: got bitti=%b v=%b m=%b expected 1/0/0", bitti, dugum_gecerli, mesgul);
    end
    tick();
    vectors++;
    if (bitti !== 1'b0 || kalan !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL level2_idle: got bitti=%b kalan=%0d expected 0/0", bitti, kalan);
    end
  endtask

  // Illegal level: hata pulse, no sequence, dugum/kalan left alone
  task automatic test_hata;
    seviye = 3'd4;
    baslat = 1'b1;
    tick();
    baslat = 1'b0;
    vectors++;
    if (hata !== 1'b1 || mesgul !== 1'b0 || dugum_gecerli !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hata_pulse: got hata=%b m=%b v=%b expected 1/0/0", hata, mesgul, dugum_gecerli);
    end
    vectors++;
    if (dugum !== beklenen(2, 3) || kalan !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL hata_hold: got dugum=%0d kalan=%0d expected %0d/0", dugum, kalan, beklenen(2, 3));
    end
    tick();
    vectors++;
    if (hata !== 1'b0 || mesgul !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hata_clear: got hata=%b m=%b expected 0/0", hata, mesgul);
    end
  endtask

  // Level 0 gives exactly node 0 and then DONE
  task automatic test_level0;
    dugum_hazir = 1'b1;
    seviye = 3'd0;
    baslat = 1'b1;
    tick();
    baslat = 1'b0;
    vectors++;
    if (dugum_gecerli !== 1'b1 || dugum !== 4'd0 || kalan !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL level0_node: got v=%b dugum=%0d kalan=%0d expected 1/0/1", dugum_gecerli, dugum, kalan);
    end
    tick();
    vectors++;
    if (bitti !== 1'b1 || dugum_gecerli !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL level0_done: got bitti=%b v=%b expected 1/0", bitti, dugum_gecerli);
    end
    tick();
  endtask

  // Level 3 with dugum_hazir toggling; every node once, held during stalls
  task automatic test_stall;
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    seviye = 3'd3;
    baslat = 1'b1;
    dugum_hazir = 1'b0;
    tick();
    baslat = 1'b0;
    while (n < 8 && cyc < 40) begin
      dugum_hazir = (cyc % 2 == 0);
      vectors++;
      if (dugum_gecerli !== 1'b1 || dugum !== beklenen(3, n) || kalan !== W'(8 - n)) begin
        miscompares++;
        $display("[TB] FAIL stall_cyc%0d: got v=%b dugum=%0d kalan=%0d expected v=1 dugum=%0d kalan=%0d",
                 cyc, dugum_gecerli, dugum, kalan, beklenen(3, n), 8 - n);
      end
      if (dugum_hazir) n++;
      tick();
      cyc++;
    end
    vectors++;
    if (n !== 8 || cyc !== 15) begin
      miscompares++;
      $display("[TB] FAIL stall_count: got transfers=%0d cycles=%0d expected 8/15", n, cyc);
    end
    vectors++;
    if (bitti !== 1'b1 || dugum_gecerli !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_done: got bitti=%b v=%b expected 1/0", bitti, dugum_gecerli);
    end
    dugum_hazir = 1'b1;
    tick();
  endtask

  // Reset in the middle of level 3, coincident with baslat, then restart
  task automatic test_rst_abort;
    dugum_hazir = 1'b1;
    seviye = 3'd3;
    baslat = 1'b1;
    tick();
    baslat = 1'b0;
    tick();
    tick();
    tick();
    vectors++;
    if (dugum !== beklenen(3, 3) || kalan !== 4'd5) begin
      miscompares++;
      $display("[TB] FAIL abort_pre: got dugum=%0d kalan=%0d expected %0d/5", dugum, kalan, beklenen(3, 3));
    end
    rst = 1'b1;
    baslat = 1'b1;
    tick();
    rst = 1'b0;
    baslat = 1'b0;
    vectors++;
    if ({dugum_gecerli, mesgul, bitti, hata} !== 4'b0000 || dugum !== 4'd0 || kalan !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL abort_reset: got flags=%b dugum=%0d kalan=%0d expected 0000/0/0",
               {dugum_gecerli, mesgul, bitti, hata}, dugum, kalan);
    end
    tick();
    vectors++;
    if (bitti !== 1'b0 || mesgul !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_nobitti: got bitti=%b m=%b expected 0/0", bitti, mesgul);
    end
    baslat = 1'b1;
    tick();
    baslat = 1'b0;
    vectors++;
    if (dugum_gecerli !== 1'b1 || dugum !== beklenen(3, 0) || kalan !== 4'd8) begin
      miscompares++;
      $display("[TB] FAIL abort_restart: got v=%b dugum=%0d kalan=%0d expected 1/%0d/8",
               dugum_gecerli, dugum, kalan, beklenen(3, 0));
    end
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (bitti !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_drain: got bitti=%b expected 1", bitti);
    end
    tick();
  endtask

  // baslat held high for level 1: ignored in EMIT and DONE
  task automatic test_back_to_back;
    dugum_hazir = 1'b1;
    seviye = 3'd1;
    baslat = 1'b1;
    tick();
    vectors++;
    if (dugum_gecerli !== 1'b1 || dugum !== beklenen(1, 0) || kalan !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL held_node0: got v=%b dugum=%0d kalan=%0d expected 1/%0d/2", dugum_gecerli, dugum, kalan, beklenen(1, 0));
    end
    tick();
    vectors++;
    if (dugum_gecerli !== 1'b1 || dugum !== beklenen(1, 1) || kalan !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL held_node1: got v=%b dugum=%0d kalan=%0d expected 1/%0d/1", dugum_gecerli, dugum, kalan, beklenen(1, 1));
    end
    tick();
    vectors++;
    if (bitti !== 1'b1 || dugum_gecerli !== 1'b0 || mesgul !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_done: got bitti=%b v=%b m=%b expected 1/0/0", bitti, dugum_gecerli, mesgul);
    end
    tick();
    vectors++;
    if (bitti !== 1'b0 || dugum_gecerli !== 1'b0 || mesgul !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_idle: got bitti=%b v=%b m=%b expected 0/0/0", bitti, dugum_gecerli, mesgul);
    end
    tick();
    baslat = 1'b0;
    vectors++;
    if (dugum_gecerli !== 1'b1 || dugum !== beklenen(1, 0) || kalan !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL held_restart: got v=%b dugum=%0d kalan=%0d expected 1/%0d/2", dugum_gecerli, dugum, kalan, beklenen(1, 0));
    end
    tick();
    tick();
    vectors++;
    if (bitti !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL held_redone: got bitti=%b expected 1", bitti);
    end
    tick();
  endtask

  // Scenario sequence
  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    baslat = 1'b0;
    seviye = 3'd0;
    dugum_hazir = 1'b0;
    test_reset();
    test_level2();
    test_hata();
    test_level0();
    test_stall();
    test_rst_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
